// File: rtl/uart_tx_pkg.sv
// Shared constants and types for the UART transmit device.
package uart_tx_pkg;

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  localparam int unsigned STAT_FULL   = 0;
  localparam int unsigned STAT_EMPTY  = 1;
  localparam int unsigned STAT_BUSY   = 2;
  localparam int unsigned STAT_IRQ_EN = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with show-ahead read data; push and pop may coincide.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_device.sv
// Bus-attached UART transmitter with byte FIFO and programmable bit divisor.
// Define UART_TX_IRQ_EN to enable the FIFO-drained interrupt.
module uart_tx_device
  import uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned DEFAULT_DIVISOR = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] address,
  input  logic [3:0]  wstrobe,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        txd,
  output logic        irq
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        reg_idx;
  logic              is_write;
  logic              data_wr;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              busy;
  logic              irq_en;
  logic [CNT_W-1:0]  fifo_count;
  logic [BYTE_W-1:0] fifo_rdata;
  logic [DIV_W-1:0]  divisor;
  logic [DIV_W-1:0]  div_eff;
  logic [DIV_W-1:0]  div_lat, div_lat_d;
  logic [DIV_W-1:0]  baud_cnt, baud_cnt_d;
  logic [2:0]        bit_cnt, bit_cnt_d;
  logic [BYTE_W-1:0] shreg, shreg_d;
  logic              txd_d;
  tx_state_e         state, state_d;
  logic              unused_ok;

  assign reg_idx  = address[3:2];
  assign is_write = |wstrobe;
  assign data_wr  = is_write && (reg_idx == REG_DATA);
  assign ready    = valid && !(data_wr && full);
  assign push     = ready && data_wr && wstrobe[0];
  assign busy     = (state != ST_IDLE);
  assign div_eff  = (divisor == '0) ? DIV_W'(1) : divisor;
  assign unused_ok = ^{address[31:4], address[1:0], wdata[31:16], fifo_count};

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divisor <= DIV_W'(DEFAULT_DIVISOR);
    end else if (ready && is_write && (reg_idx == REG_DIVISOR)) begin
      divisor <= wdata[DIV_W-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_STATUS:  rdata = 32'({irq_en, busy, empty, full});
      REG_DIVISOR: rdata = 32'(divisor);
      default:     rdata = '0;
    endcase
  end

`ifdef UART_TX_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ready && is_write && (reg_idx == REG_STATUS)) irq_en <= wdata[STAT_IRQ_EN];
      irq <= irq_en && empty && !busy;
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      txd      <= 1'b1;
      div_lat  <= DIV_W'(1);
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_d;
      txd      <= txd_d;
      div_lat  <= div_lat_d;
      baud_cnt <= baud_cnt_d;
      bit_cnt  <= bit_cnt_d;
      shreg    <= shreg_d;
    end
  end

  // Each frame phase lasts div_lat cycles; the next frame starts straight out of STOP.
  always_comb begin
    state_d    = state;
    div_lat_d  = div_lat;
    baud_cnt_d = baud_cnt;
    bit_cnt_d  = bit_cnt;
    shreg_d    = shreg;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shreg_d    = fifo_rdata;
          div_lat_d  = div_eff;
          baud_cnt_d = '0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (baud_cnt == div_lat - DIV_W'(1)) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = ST_DATA;
        end else begin
          baud_cnt_d = baud_cnt + DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_cnt == div_lat - DIV_W'(1)) begin
          baud_cnt_d = '0;
          shreg_d    = shreg >> 1;
          if (bit_cnt == 3'd7) state_d = ST_STOP;
          else                 bit_cnt_d = bit_cnt + 3'd1;
        end else begin
          baud_cnt_d = baud_cnt + DIV_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_cnt == div_lat - DIV_W'(1)) begin
          baud_cnt_d = '0;
          if (!empty) begin
            pop       = 1'b1;
            shreg_d   = fifo_rdata;
            div_lat_d = div_eff;
            state_d   = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shreg_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

endmodule
